// File: rtl/screen_mux_pkg.sv
// screen_mux_pkg: shared types and constants for the screen selector.
//   state_t   - switch FSM states
//   MODE_*    - switch style selector values
//   RGB_W     - packed {r,g,b} width, 4 bits per component
//   CNT_W     - h/v counter width
//   dim_rgb() - per-component saturating subtract used for fade-through-black
package screen_mux_pkg;

  typedef enum logic [1:0] {IDLE, PEND, FADE_OUT, FADE_IN} state_t;

  localparam int MODE_CUT  = 0;
  localparam int MODE_FADE = 1;
  localparam int RGB_W     = 12;
  localparam int CNT_W     = 12;

  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] c,
                                               input logic [3:0]       d);
    logic [RGB_W-1:0] r;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = (c[4*i +: 4] > d) ? (c[4*i +: 4] - d) : 4'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/screen_mux_if.sv
// screen_mux_if: bundle of the N input VGA streams, the request handshake,
// the mouse inputs and the selected output stream.
//   master - drives streams, request and mouse; observes outputs
//   slave  - the selector itself
interface screen_mux_if #(
  parameter int N_SCREENS = 4,
  parameter int SEL_W     = $clog2(N_SCREENS)
);
  import screen_mux_pkg::*;

  logic [N_SCREENS*CNT_W-1:0] hcount_in;
  logic [N_SCREENS*CNT_W-1:0] vcount_in;
  logic [N_SCREENS-1:0]       hsync_in;
  logic [N_SCREENS-1:0]       vsync_in;
  logic [N_SCREENS-1:0]       hblnk_in;
  logic [N_SCREENS-1:0]       vblnk_in;
  logic [N_SCREENS*RGB_W-1:0] rgb_in;

  logic                       req_valid;
  logic [SEL_W-1:0]           req_sel;
  logic                       req_ready;

  logic                       mouse_left;
  logic [CNT_W-1:0]           xpos;
  logic [CNT_W-1:0]           ypos;

  logic [CNT_W-1:0]           hcount_out;
  logic [CNT_W-1:0]           vcount_out;
  logic                       hsync_out;
  logic                       vsync_out;
  logic                       hblnk_out;
  logic                       vblnk_out;
  logic [RGB_W-1:0]           rgb_out;

  logic [SEL_W-1:0]           cur_sel;
  logic                       busy;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output req_valid, req_sel, mouse_left, xpos, ypos,
    input  req_ready, hcount_out, vcount_out, hsync_out, vsync_out,
    input  hblnk_out, vblnk_out, rgb_out, cur_sel, busy
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  req_valid, req_sel, mouse_left, xpos, ypos,
    output req_ready, hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, rgb_out, cur_sel, busy
  );

endinterface

// File: rtl/screen_mux_frame_tick_det.sv
// frame_tick_det: one-cycle pulse on the rising edge of the selected vblnk.
//   pclk, rst - clock, async active-high reset
//   vblnk     - vblnk of the stream currently selected
//   clear     - synchronous clear, asserted on the cycle the source changes
//   tick      - frame boundary pulse
module frame_tick_det (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk,
  input  logic clear,
  output logic tick
);

  logic vblnk_q, vblnk_d;
  logic armed_q, armed_d;

  // After a clear the new source may already be in blanking. armed_q holds
  // off the tick until that source has been seen low, so a swap never
  // produces a false frame boundary on the following cycle.
  always_comb begin
    vblnk_d = vblnk;
    armed_d = armed_q | ~vblnk;
    if (clear) begin
      vblnk_d = 1'b0;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk_d;
      armed_q <= armed_d;
    end
  end

  assign tick = vblnk & ~vblnk_q & armed_q;

endmodule

// File: rtl/screen_mux.sv
// screen_mux: frame-synchronous selector for N parallel VGA streams.
//   pclk, rst - pixel clock, async active-high reset
//   bus       - screen_mux_if slave: packed input streams, request
//               handshake, mouse, registered output stream, cur_sel, busy
//
// state    | meaning
// IDLE     | accepting requests and start-button clicks
// PEND     | cut pending, swap at next frame tick
// FADE_OUT | dim rises one step per frame, swap when it hits FADE_MAX
// FADE_IN  | dim falls one step per frame, back to IDLE at 0
module screen_mux
  import screen_mux_pkg::*;
#(
  parameter int         N_SCREENS = 4,
  parameter int         SEL_W     = $clog2(N_SCREENS),
  parameter int         MODE      = 0,
  parameter logic [3:0] FADE_MAX  = 4'd15,
  parameter logic [11:0] BTN_X0   = 12'd448,
  parameter logic [11:0] BTN_X1   = 12'd575,
  parameter logic [11:0] BTN_Y0   = 12'd352,
  parameter logic [11:0] BTN_Y1   = 12'd415
) (
  input logic         pclk,
  input logic         rst,
  screen_mux_if.slave bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] nxt_sel_q, nxt_sel_d;
  logic [3:0]       dim_q, dim_d;
  logic             mouse_q;
  logic             tick, swap, click, in_btn;
  logic [SEL_W-1:0] target;
  int               sel_i;

  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d, vblnk_q, vblnk_d;

  assign sel_i = int'(cur_sel_q);

  frame_tick_det u_tick (
    .pclk  (pclk),
    .rst   (rst),
    .vblnk (bus.vblnk_in[cur_sel_q]),
    .clear (swap),
    .tick  (tick)
  );

  assign in_btn = (bus.xpos >= BTN_X0) && (bus.xpos <= BTN_X1) &&
                  (bus.ypos >= BTN_Y0) && (bus.ypos <= BTN_Y1);
  assign click  = bus.mouse_left && !mouse_q && (cur_sel_q == '0) && in_btn;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    nxt_sel_d = nxt_sel_q;
    dim_d     = dim_q;
    swap      = 1'b0;
    // External request wins over a simultaneous click.
    target    = bus.req_valid ? bus.req_sel : SEL_W'(1);
    case (state_q)
      IDLE: begin
        if ((bus.req_valid || click) &&
            (int'(target) < N_SCREENS) && (target != cur_sel_q)) begin
          nxt_sel_d = target;
          state_d   = (MODE == MODE_FADE) ? FADE_OUT : PEND;
        end
      end
      PEND: begin
        if (tick) begin
          cur_sel_d = nxt_sel_q;
          swap      = 1'b1;
          state_d   = IDLE;
        end
      end
      FADE_OUT: begin
        if (tick) begin
          dim_d = dim_q + 4'd1;
          if (dim_d == FADE_MAX) begin
            cur_sel_d = nxt_sel_q;
            swap      = 1'b1;
            state_d   = FADE_IN;
          end
        end
      end
      FADE_IN: begin
        if (tick) begin
          dim_d = dim_q - 4'd1;
          if (dim_d == 4'd0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hcount_d = bus.hcount_in[sel_i*CNT_W +: CNT_W];
    vcount_d = bus.vcount_in[sel_i*CNT_W +: CNT_W];
    hsync_d  = bus.hsync_in[cur_sel_q];
    vsync_d  = bus.vsync_in[cur_sel_q];
    hblnk_d  = bus.hblnk_in[cur_sel_q];
    vblnk_d  = bus.vblnk_in[cur_sel_q];
    rgb_d    = dim_rgb(bus.rgb_in[sel_i*RGB_W +: RGB_W], dim_q);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      nxt_sel_q <= '0;
      dim_q     <= 4'd0;
      mouse_q   <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      hblnk_q   <= 1'b0;
      vblnk_q   <= 1'b0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      nxt_sel_q <= nxt_sel_d;
      dim_q     <= dim_d;
      mouse_q   <= bus.mouse_left;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      hblnk_q   <= hblnk_d;
      vblnk_q   <= vblnk_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.cur_sel    = cur_sel_q;
  assign bus.hcount_out = hcount_q;
  assign bus.vcount_out = vcount_q;
  assign bus.hsync_out  = hsync_q;
  assign bus.vsync_out  = vsync_q;
  assign bus.hblnk_out  = hblnk_q;
  assign bus.vblnk_out  = vblnk_q;
  assign bus.rgb_out    = rgb_q;

endmodule
